// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N-channel synchroniser, prescaled debounce, edge events, sticky flags
// Optional toggle outputs are built only when INCOND_TOGGLE_EN is defined.
module input_conditioner #(
    parameter int N           = 21,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1000,
    parameter int STABLE      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic [N-1:0] clr,
    input  logic [N-1:0] tmode,
    output logic [N-1:0] q,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] events,
    output logic         any_evt,
    output logic [N-1:0] tog
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE + 1);

    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [PW-1:0]                 r_pre;
    logic [N-1:0][CW-1:0]          r_cnt;
    logic [N-1:0]                  r_q;
    logic [N-1:0]                  r_rise;
    logic [N-1:0]                  r_fall;
    logic [N-1:0]                  r_events;

    logic [N-1:0]                  w_s;
    logic                          w_tick;
    logic [N-1:0][CW-1:0]          w_cnt_nxt;
    logic [N-1:0]                  w_q_nxt;
    logic [N-1:0]                  w_rise_nxt;
    logic [N-1:0]                  w_fall_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // A differing sample only advances the count; the level flips on the STABLE-th one in a row.
    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        if (w_tick) begin
            for (int i = 0; i < N; i++) begin
                if (w_s[i] == r_q[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] + CW'(1) == CW'(STABLE)) begin
                    w_q_nxt[i]   = w_s[i];
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise_nxt = w_q_nxt & ~r_q;
    assign w_fall_nxt = ~w_q_nxt & r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_q      <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_events <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_q      <= w_q_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_events <= (r_events & ~clr) | r_rise | r_fall;
        end
    end

    assign q       = r_q;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign events  = r_events;
    assign any_evt = |r_events;

`ifdef INCOND_TOGGLE_EN
    logic [N-1:0] r_tog;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tog <= '0;
        end else begin
            r_tog <= r_tog ^ (w_rise_nxt & tmode);
        end
    end

    assign tog = r_tog;
`else
    logic w_tmode_unused;

    assign w_tmode_unused = ^tmode;
    assign tog            = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
// Toggle expectations follow INCOND_TOGGLE_EN.
module tb_input_conditioner;

    localparam int N = 4;
`ifdef INCOND_TOGGLE_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] din, clr, tmode;
    logic [N-1:0] q, rise, fall, events, tog;
    logic         any_evt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .N(N), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE(3)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .clr(clr), .tmode(tmode),
        .q(q), .rise(rise), .fall(fall), .events(events), .any_evt(any_evt), .tog(tog)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"}, q, 0);
        check({tag, "_rise"}, rise, 0);
        check({tag, "_fall"}, fall, 0);
        check({tag, "_events"}, events, 0);
        check({tag, "_any"}, any_evt, 0);
        check({tag, "_tog"}, tog, 0);
    endtask

    // Waits up to limit clks for (vec & mask) != 0; returns the clk count, 0 if never seen.
    task automatic wait_mask(input int sel, input logic [N-1:0] mask, input int limit,
                             output int lat);
        logic [N-1:0] v;
        lat = 0;
        for (int c = 1; c <= limit && lat == 0; c++) begin
            step();
            v = (sel == 0) ? q : (sel == 1) ? rise : fall;
            if ((v & mask) != 0) lat = c;
        end
    endtask

    initial begin
        int           lat;
        logic [N-1:0] acc;
        logic [N-1:0] fall_acc;
        logic         exp_tog;

        reset = 1'b0;
        din   = '0;
        clr   = '0;
        tmode = '0;
        repeat (3) step();
        check_all_zero("reset");

        // Release between edges: prescaler is 0, so ticks land on the 4th, 8th, 12th edges.
        reset  = 1'b1;
        din[0] = 1'b1;
        lat = 0;
        fall_acc = '0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            step();
            fall_acc |= fall;
            if (q[0]) begin
                lat = c;
                check("t1_rise_first", rise, 4'b0001);
            end
        end
        check("t1_latency", lat, 12);
        step();
        fall_acc |= fall;
        check("t1_rise_one_clk", rise, 0);
        check("t1_q_held", q, 4'b0001);
        check("t1_events", events, 4'b0001);
        check("t1_any_evt", any_evt, 1);
        check("t1_no_fall", fall_acc, 0);

        // Glitch of two ticks on channel 1 must not move q.
        din[1] = 1'b1;
        acc = '0;
        repeat (8) begin
            step();
            acc |= q | rise | fall | events;
        end
        din[1] = 1'b0;
        repeat (12) begin
            step();
            acc |= q | rise | fall | events;
        end
        check("t2_glitch", acc & 4'b0010, 0);

        // Counter restarted from 0: a clean press needs a full three ticks again.
        din[1] = 1'b1;
        wait_mask(0, 4'b0010, 20, lat);
        check("t2_cnt_restart_lat", lat, 11);
        din[1] = 1'b0;
        wait_mask(2, 4'b0010, 20, lat);
        check("t2_fall_seen", lat != 0, 1);
        step();

        clr = 4'b0001;
        step();
        clr = '0;
        check("t3_clr_only", events, 4'b0010);
        clr = 4'b0010;
        step();
        clr = '0;
        din[0] = 1'b0;
        wait_mask(2, 4'b0001, 20, lat);
        check("t3_fall_seen", lat != 0, 1);
        clr = 4'b0001;
        step();
        clr = '0;
        check("t3_set_beats_clr", events, 4'b0001);
        clr = 4'b1111;
        step();
        clr = '0;
        check("t3_cleared", events, 0);
        check("t3_any_clear", any_evt, 0);

        din[2] = 1'b1;
        repeat (8) step();
        reset = 1'b0;
        #1;
        check_all_zero("t4_in_reset");
        repeat (3) step();
        check_all_zero("t4_reset_held");
        reset = 1'b1;
        repeat (11) step();
        check("t4_early", q, 0);
        step();
        check("t4_q", q, 4'b0100);
        check("t4_rise", rise, 4'b0100);

        tmode   = 4'b0001;
        exp_tog = 1'b0;
        for (int p = 0; p < 3; p++) begin
            check("t5_tog_before", tog, {3'b000, exp_tog});
            din[0] = 1'b1;
            wait_mask(1, 4'b0001, 20, lat);
            check("t5_rise_seen", lat != 0, 1);
            if (TOG_EN) exp_tog = ~exp_tog;
            check("t5_tog_at_rise", tog, {3'b000, exp_tog});
            din[0] = 1'b0;
            wait_mask(2, 4'b0001, 20, lat);
            check("t5_fall_seen", lat != 0, 1);
        end
        check("t5_tog_final", tog, {3'b000, TOG_EN});

        tmode = '0;
        din   = '0;
        lat   = 0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            step();
            if (q == 0) lat = c;
        end
        check("t6_idle", lat != 0, 1);
        step();
        clr = 4'b1111;
        step();
        clr = '0;
        din = 4'b1111;
        wait_mask(0, 4'b1111, 20, lat);
        check("t6_q_all", q, 4'b1111);
        check("t6_rise_all", rise, 4'b1111);
        step();
        check("t6_events_all", events, 4'b1111);
        clr = 4'b0101;
        step();
        clr = '0;
        check("t6_partial_clr", events, 4'b1010);
        check("t6_any", any_evt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
